// File: rtl/mult_pipe_pkg.sv
// Shared types for the pipelined RV32M multiplier: function encoding,
// default widths, the per-stage payload and the operand-extension rules.
package mult_pipe_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'h0,
    MULT_MULH   = 2'h1,
    MULT_MULHSU = 2'h2,
    MULT_MULHU  = 2'h3
  } MULT_FUNC;

  typedef struct packed {
    logic [2*XLEN-1:0] psum;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] mplier;
    MULT_FUNC          func;
    logic [TAG_W-1:0]  tag;
    logic              valid;
  } MULT_STAGE_PACKET;

  function automatic logic opa_is_signed(input MULT_FUNC f);
    return (f != MULT_MULHU);
  endfunction

  function automatic logic opb_is_signed(input MULT_FUNC f);
    return (f == MULT_MUL) || (f == MULT_MULH);
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: multiply the multiplicand by the low chunk of
// the remaining multiplier, accumulate, then register with enable and clear.
module mult_stage
  import mult_pipe_pkg::*;
#(
  parameter int XLEN  = mult_pipe_pkg::XLEN,
  parameter int CHUNK = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             clr_i,
  input  MULT_STAGE_PACKET pkt_i,
  output MULT_STAGE_PACKET pkt_o
);

  localparam int PW = 2 * XLEN;
  localparam logic [PW-1:0] CHUNK_MASK = {PW{1'b1}} >> (PW - CHUNK);

  MULT_STAGE_PACKET pkt_d;
  MULT_STAGE_PACKET pkt_q;
  logic [PW-1:0]    chunk;

  // Chunk multiply-accumulate; multiplicand and multiplier shift for the next stage
  always_comb begin
    pkt_d        = pkt_i;
    chunk        = pkt_i.mplier & CHUNK_MASK;
    pkt_d.psum   = pkt_i.psum + (pkt_i.mcand * chunk);
    pkt_d.mcand  = pkt_i.mcand << CHUNK;
    pkt_d.mplier = pkt_i.mplier >> CHUNK;
  end

  // Stage register: squash drops only the valid bit, stall holds everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_q <= '0;
    end else if (clr_i) begin
      pkt_q.valid <= 1'b0;
    end else if (en_i) begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_o = pkt_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a tag carried per op,
// global back-pressure stall and branch-mispredict squash.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int XLEN       = mult_pipe_pkg::XLEN,
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = mult_pipe_pkg::TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  MULT_FUNC         in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CHUNK = (2 * XLEN) / NUM_STAGES;

  MULT_STAGE_PACKET head_pkt;
  MULT_STAGE_PACKET last_pkt;
  MULT_STAGE_PACKET stage_out [NUM_STAGES];
  logic             advance;
  logic             a_sgn;
  logic             b_sgn;
  logic             unused_last_bits;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !squash;

  // Operand extension to 2*XLEN and first-stage payload
  always_comb begin
    a_sgn           = opa_is_signed(in_func);
    b_sgn           = opb_is_signed(in_func);
    head_pkt        = '0;
    head_pkt.mcand  = {{XLEN{in_opa[XLEN-1] & a_sgn}}, in_opa};
    head_pkt.mplier = {{XLEN{in_opb[XLEN-1] & b_sgn}}, in_opb};
    head_pkt.func   = in_func;
    head_pkt.tag    = in_tag;
    head_pkt.valid  = in_valid && in_ready;
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    MULT_STAGE_PACKET stage_in;
    if (g == 0) begin : g_first
      assign stage_in = head_pkt;
    end else begin : g_chain
      assign stage_in = stage_out[g-1];
    end

    mult_stage #(
      .XLEN  (XLEN),
      .CHUNK (CHUNK)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .en_i  (advance),
      .clr_i (squash),
      .pkt_i (stage_in),
      .pkt_o (stage_out[g])
    );
  end

  assign last_pkt = stage_out[NUM_STAGES-1];

  // Result select from the registered final product
  always_comb begin
    out_valid = last_pkt.valid;
    out_tag   = last_pkt.tag;
    if (last_pkt.func == MULT_MUL) begin
      out_result = last_pkt.psum[XLEN-1:0];
    end else begin
      out_result = last_pkt.psum[2*XLEN-1:XLEN];
    end
  end

  assign unused_last_bits = ^{last_pkt.mcand, last_pkt.mplier};

endmodule

// File: tb/tb_mult_pipe.sv
// Directed and random checks of mult_pipe; instance 0 uses 4 stages, the
// others 1, 2 and 8 stages and are exercised by the random reference phase.
module tb_mult_pipe;
  import mult_pipe_pkg::*;

  localparam int ND = 4;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        squash    = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_opa    = 32'h0;
  logic [31:0] in_opb    = 32'h0;
  MULT_FUNC    in_func   = MULT_MUL;
  logic [5:0]  in_tag    = 6'h0;

  logic        in_ready_w   [ND];
  logic        out_valid_w  [ND];
  logic [31:0] out_result_w [ND];
  logic [5:0]  out_tag_w    [ND];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  function automatic int ns_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : (d == 2) ? 2 : 8;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int NS = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    mult_pipe #(.XLEN(32), .NUM_STAGES(NS), .TAG_W(6)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .squash     (squash),
      .in_valid   (in_valid),
      .in_ready   (in_ready_w[g]),
      .in_opa     (in_opa),
      .in_opb     (in_opb),
      .in_func    (in_func),
      .in_tag     (in_tag),
      .out_valid  (out_valid_w[g]),
      .out_ready  (out_ready),
      .out_result (out_result_w[g]),
      .out_tag    (out_tag_w[g])
    );
  end

  typedef struct {
    MULT_FUNC    f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [5:0]  t;
    int          iss;
  } op_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input MULT_FUNC f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t);
    in_valid = 1'b1;
    in_func  = f;
    in_opa   = a;
    in_opb   = b;
    in_tag   = t;
  endtask

  function automatic logic [31:0] ref_mul(input MULT_FUNC f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (f == MULT_MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
    eb = (f == MULT_MUL || f == MULT_MULH) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (f == MULT_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [10];
    op_t  ops [$];
    int   ptr [ND];
    int   got;
    int   lat;
    int   n;
    logic exp_v;

    vt[0] = '{MULT_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 6'd5,  32'hFFFF_FFEB};
    vt[1] = '{MULT_MULH,   32'h8000_0000, 32'h8000_0000, 6'd6,  32'h4000_0000};
    vt[2] = '{MULT_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7,  32'hFFFF_FFFF};
    vt[3] = '{MULT_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd8,  32'hFFFF_FFFE};
    vt[4] = '{MULT_MUL,    32'h1234_5678, 32'h0000_0010, 6'd9,  32'h2345_6780};
    vt[5] = '{MULT_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 32'h0000_0000};
    vt[6] = '{MULT_MULHU,  32'h8000_0000, 32'h0000_0002, 6'd11, 32'h0000_0001};
    vt[7] = '{MULT_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'd12, 32'h3FFF_FFFF};
    vt[8] = '{MULT_MULHSU, 32'h8000_0000, 32'h0000_0002, 6'd13, 32'hFFFF_FFFF};
    vt[9] = '{MULT_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 32'h0000_0001};

    // reset state
    #1;
    chk("reset_valid", out_valid_w[0], 64'd0);
    chk("reset_result", out_result_w[0], 64'd0);
    chk("reset_tag", out_tag_w[0], 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("reset_ready", in_ready_w[0], 64'd1);

    // back-to-back table, latency 4, consecutive in-order results
    got = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) drive(vt[c].f, vt[c].a, vt[c].b, vt[c].tag);
      else in_valid = 1'b0;
      step();
      chk($sformatf("tbl_valid_c%0d", c), out_valid_w[0], 64'((c >= 3) && (c < 13)));
      if (out_valid_w[0]) begin
        if (got < 10) begin
          chk($sformatf("tbl_result_%0d", got), out_result_w[0], vt[got].exp);
          chk($sformatf("tbl_tag_%0d", got), out_tag_w[0], vt[got].tag);
        end
        got++;
      end
    end
    chk("tbl_count", got, 10);

    // stall: four in flight, consumer blocks for 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(MULT_MUL, 32'(i + 2), 32'd3, 6'(20 + i));
      step();
    end
    drive(MULT_MULHU, 32'h0000_DEAD, 32'h0000_BEEF, 6'd40);
    chk("stall_first_valid", out_valid_w[0], 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_ready", in_ready_w[0], 64'd0);
      step();
      chk("stall_valid", out_valid_w[0], 64'd1);
      chk("stall_result", out_result_w[0], 64'd6);
      chk("stall_tag", out_tag_w[0], 64'd20);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid_w[0]) begin
        if (got < 4) begin
          chk("drain_result", out_result_w[0], 64'(3 * (got + 2)));
          chk("drain_tag", out_tag_w[0], 64'(20 + got));
        end
        got++;
      end
      step();
    end
    chk("drain_count", got, 4);

    // squash with three in flight and a simultaneous issue attempt
    for (int i = 0; i < 3; i++) begin
      drive(MULT_MUL, 32'(100 + i), 32'd2, 6'(30 + i));
      step();
    end
    squash = 1'b1;
    drive(MULT_MUL, 32'd9, 32'd9, 6'd33);
    #1;
    chk("squash_ready", in_ready_w[0], 64'd0);
    step();
    squash   = 1'b0;
    in_valid = 1'b0;
    chk("squash_valid", out_valid_w[0], 64'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("squash_none", out_valid_w[0], 64'd0);
    end
    drive(MULT_MUL, 32'd5, 32'd6, 6'd34);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid_w[0] && lat < 12) begin
      step();
      lat++;
    end
    chk("post_squash_latency", lat, 4);
    chk("post_squash_result", out_result_w[0], 64'd30);
    chk("post_squash_tag", out_tag_w[0], 64'd34);
    step();

    // asynchronous reset in the middle of a stream
    for (int i = 0; i < 5; i++) begin
      drive(MULT_MUL, 32'(i + 1), 32'd7, 6'(50 + i));
      step();
    end
    in_valid = 1'b0;
    chk("rst_pre_valid", out_valid_w[0], 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", out_valid_w[0], 64'd0);
    chk("rst_result", out_result_w[0], 64'd0);
    chk("rst_tag", out_tag_w[0], 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", in_ready_w[0], 64'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rst_stale", out_valid_w[0], 64'd0);
    end

    // random ops against the reference model on all four depths
    reset = 1'b0;
    #2 reset = 1'b1;
    step();
    n = 0;
    for (int d = 0; d < ND; d++) ptr[d] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc < 280 && $urandom_range(3) != 0) begin
        MULT_FUNC    f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  t;
        f = MULT_FUNC'($urandom_range(3));
        a = pick_operand();
        b = pick_operand();
        t = 6'($urandom_range(63));
        drive(f, a, b, t);
        ops.push_back('{ref_mul(f, a, b), t, n + 1});
      end else begin
        in_valid = 1'b0;
      end
      step();
      n++;
      for (int d = 0; d < ND; d++) begin
        exp_v = (ptr[d] < ops.size()) && (ops[ptr[d]].iss + ns_of(d) - 1 == n);
        chk($sformatf("rnd_valid_ns%0d", ns_of(d)), out_valid_w[d], 64'(exp_v));
        if (out_valid_w[d] && exp_v) begin
          chk($sformatf("rnd_result_ns%0d", ns_of(d)), out_result_w[d], ops[ptr[d]].r);
          chk($sformatf("rnd_tag_ns%0d", ns_of(d)), out_tag_w[d], ops[ptr[d]].t);
          ptr[d]++;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rnd_count_ns%0d", ns_of(d)), ptr[d], ops.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
